// File: rtl/microc_stack.sv
// microc_stack: microcontroller datapath with 16-entry register file, ALU, zero/carry flags and return-address stack.
// Ports: clk, reset (async active-low); instr program word read at pc; control s_inc, s_inm, we3, wez, op, s_call, s_ret;
//        outputs pc, opcode (instr[15:10]), z, c, stk_lvl (stack occupancy), stk_err (sticky over/underflow).
// Build option: MICROC_STACK_CARRY_EN adds the carry/borrow flag; otherwise c is tied to 0.
module microc_stack #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  localparam int LW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic          s_inc,
  input  logic          s_inm,
  input  logic          we3,
  input  logic          wez,
  input  logic [2:0]    op,
  input  logic          s_call,
  input  logic          s_ret,
  output logic [PC_W-1:0] pc,
  output logic [5:0]    opcode,
  output logic          z,
  output logic          c,
  output logic [LW-1:0] stk_lvl,
  output logic          stk_err
);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [DATA_W-1:0] rf_q [16];
  logic [PC_W-1:0]   stk_q [STACK_DEPTH];
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, tgt;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              z_q, z_d, err_q, err_d;
  logic [3:0]        ra1, ra2, wa3;
  logic [DATA_W-1:0] rd1, rd2, a, b, res;
  logic              empty, full, push, pop;
  logic [IW-1:0]     push_idx, pop_idx;

  assign ra1 = instr[11:8];
  assign ra2 = s_inm ? instr[3:0] : instr[7:4];
  assign wa3 = instr[3:0];
  assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];
  assign a   = s_inm ? DATA_W'(instr[11:4]) : rd1;
  assign b   = rd2;

  always_comb begin
    res = a;
    case (op)
      3'b001:  res = ~a;
      3'b010:  res = a + b;
      3'b011:  res = a - b;
      3'b100:  res = a & b;
      3'b101:  res = a | b;
      3'b110:  res = -a;
      3'b111:  res = -b;
      default: res = a;
    endcase
  end

  // R0 is never written; its reads are forced to zero above.
  always_ff @(posedge clk)
    if (we3 && wa3 != 4'd0) rf_q[wa3] <= res;

  assign pc_inc   = pc_q + PC_W'(1);
  assign tgt      = instr[PC_W-1:0];
  assign empty    = (lvl_q == '0);
  assign full     = (lvl_q == LW'(STACK_DEPTH));
  assign push_idx = IW'(lvl_q);
  assign pop_idx  = IW'(lvl_q - LW'(1));
  // A return always wins; a simultaneous call is dropped entirely.
  assign pop      = s_ret && !empty;
  assign push     = s_call && !s_ret && !full;

  always_comb begin
    pc_d  = s_ret ? (empty ? pc_inc : stk_q[pop_idx]) : (s_call || !s_inc) ? tgt : pc_inc;
    lvl_d = pop ? lvl_q - LW'(1) : push ? lvl_q + LW'(1) : lvl_q;
    err_d = err_q || (s_ret && empty) || (s_call && !s_ret && full);
    z_d   = wez ? (res == '0) : z_q;
  end

  always_ff @(posedge clk)
    if (push) stk_q[push_idx] <= pc_inc;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q  <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
      z_q   <= z_d;
    end

`ifdef MICROC_STACK_CARRY_EN
  logic              c_q, c_d;
  logic [DATA_W:0]   sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign c_d = (wez && op == 3'b010) ? sum[DATA_W] : (wez && op == 3'b011) ? (a < b) : c_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) c_q <= 1'b0;
    else        c_q <= c_d;
  assign c = c_q;
`else
  assign c = 1'b0;
`endif

  assign pc      = pc_q;
  assign opcode  = instr[15:10];
  assign z       = z_q;
  assign stk_lvl = lvl_q;
  assign stk_err = err_q;
endmodule

// File: tb/tb_microc_stack.sv
// tb_microc_stack: directed self-checking bench for microc_stack with default parameters.
module tb_microc_stack;
`ifdef MICROC_STACK_CARRY_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = '0;
  logic        s_inc = 1'b1, s_inm = 1'b0, we3 = 1'b0, wez = 1'b0, s_call = 1'b0, s_ret = 1'b0;
  logic [2:0]  op = '0;
  logic [9:0]  pc;
  logic [5:0]  opcode;
  logic        z, c, stk_err;
  logic [2:0]  stk_lvl;
  int          total = 0, bad = 0;

  typedef struct {
    logic [15:0] i;
    bit          inm;
    logic [2:0]  o;
    bit          w3, wz, ez, ec;
  } row_t;

  row_t alu_rows[19] = '{
    '{16'h0A53, 1, 3'b000, 1, 0, 0, 0},
    '{16'h0A54, 1, 3'b000, 1, 0, 0, 0},
    '{16'h0A65, 1, 3'b000, 1, 0, 0, 0},
    '{16'h0300, 0, 3'b000, 0, 1, 0, 0},
    '{16'h0340, 0, 3'b011, 0, 1, 1, 0},
    '{16'h0350, 0, 3'b011, 0, 1, 0, 0},
    '{16'h0FF0, 1, 3'b000, 1, 0, 0, 0},
    '{16'h0000, 0, 3'b000, 0, 1, 1, 0},
    '{16'h05A4, 1, 3'b101, 0, 1, 0, 0},
    '{16'h05A4, 1, 3'b100, 0, 1, 1, 0},
    '{16'h0030, 0, 3'b111, 0, 1, 0, 0},
    '{16'h0FF0, 1, 3'b001, 0, 1, 1, 0},
    '{16'h0A50, 1, 3'b000, 0, 0, 1, 0},
    '{16'h0300, 0, 3'b110, 0, 1, 0, 0},
    '{16'h0000, 0, 3'b110, 0, 1, 1, 0},
    '{16'h0340, 0, 3'b010, 0, 1, 0, 0},
    '{16'h0346, 0, 3'b011, 1, 1, 1, 0},
    '{16'h0300, 0, 3'b000, 0, 1, 0, 0},
    '{16'h0600, 0, 3'b000, 0, 1, 1, 0}
  };

  row_t carry_rows[7] = '{
    '{16'h0011, 1, 3'b000, 1, 0, 0, 0},
    '{16'h0FF1, 1, 3'b010, 0, 1, 1, CE},
    '{16'h0011, 1, 3'b010, 0, 1, 0, 0},
    '{16'h0001, 1, 3'b011, 0, 1, 0, CE},
    '{16'h0001, 1, 3'b000, 0, 1, 1, CE},
    '{16'h0FF1, 1, 3'b010, 0, 0, 1, CE},
    '{16'h0051, 1, 3'b011, 0, 1, 0, 0}
  };

  microc_stack dut (
    .clk(clk), .reset(reset), .instr(instr), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .op(op), .s_call(s_call), .s_ret(s_ret), .pc(pc), .opcode(opcode), .z(z), .c(c),
    .stk_lvl(stk_lvl), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input bit inm, input logic [2:0] o, input bit w3, input bit wz);
    instr = i; s_inm = inm; op = o; we3 = w3; wez = wz;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if ({pc, z, c, stk_lvl, stk_err} !== 15'h0) begin bad++; $display("FAIL reset_state got pc=%h z=%b c=%b lvl=%0d err=%b exp all 0", pc, z, c, stk_lvl, stk_err); end
    total++;
    reset = 1'b1;
    tick;
    if (pc !== 10'h001) begin bad++; $display("FAIL reset_first_inc got=%h exp=001", pc); end
    total++;
  endtask

  task automatic test_opcode;
    instr = 16'hFC00;
    #1;
    if (opcode !== 6'h3F) begin bad++; $display("FAIL opcode_3f got=%h exp=3f", opcode); end
    total++;
    instr = 16'h4400;
    #1;
    if (opcode !== 6'h11) begin bad++; $display("FAIL opcode_11 got=%h exp=11", opcode); end
    total++;
    instr = 16'h0000;
  endtask

  task automatic test_alu;
    for (int k = 0; k < 19; k++) begin
      drive(alu_rows[k].i, alu_rows[k].inm, alu_rows[k].o, alu_rows[k].w3, alu_rows[k].wz);
      tick;
      if (z !== alu_rows[k].ez) begin bad++; $display("FAIL alu_row%0d z got=%b exp=%b", k, z, alu_rows[k].ez); end
      total++;
    end
    drive(16'h0000, 0, 3'b000, 0, 0);
  endtask

  task automatic test_call_ret;
    s_inc = 1'b0; instr = 16'h0010;
    tick;
    if (pc !== 10'h010) begin bad++; $display("FAIL jump_010 got=%h exp=010", pc); end
    total++;
    s_inc = 1'b1; s_call = 1'b1; instr = 16'h0100;
    tick;
    if ({pc, stk_lvl, stk_err} !== {10'h100, 3'd1, 1'b0}) begin bad++; $display("FAIL call_100 got pc=%h lvl=%0d err=%b exp pc=100 lvl=1 err=0", pc, stk_lvl, stk_err); end
    total++;
    s_call = 1'b0; s_ret = 1'b1;
    tick;
    if ({pc, stk_lvl, stk_err} !== {10'h011, 3'd0, 1'b0}) begin bad++; $display("FAIL ret_011 got pc=%h lvl=%0d err=%b exp pc=011 lvl=0 err=0", pc, stk_lvl, stk_err); end
    total++;
    s_ret = 1'b0;
  endtask

  task automatic test_wrap_and_priority;
    s_inc = 1'b0; instr = 16'h03FF;
    tick;
    if (pc !== 10'h3FF) begin bad++; $display("FAIL jump_3ff got=%h exp=3ff", pc); end
    total++;
    s_inc = 1'b1;
    tick;
    if (pc !== 10'h000) begin bad++; $display("FAIL pc_wrap got=%h exp=000", pc); end
    total++;
    s_call = 1'b1; instr = 16'h0020;
    tick;
    if ({pc, stk_lvl} !== {10'h020, 3'd1}) begin bad++; $display("FAIL call_020 got pc=%h lvl=%0d exp pc=020 lvl=1", pc, stk_lvl); end
    total++;
    s_ret = 1'b1; instr = 16'h0200;
    tick;
    if ({pc, stk_lvl, stk_err} !== {10'h001, 3'd0, 1'b0}) begin bad++; $display("FAIL call_ret_same got pc=%h lvl=%0d err=%b exp pc=001 lvl=0 err=0", pc, stk_lvl, stk_err); end
    total++;
    s_call = 1'b0; s_ret = 1'b0;
  endtask

  task automatic test_overflow;
    logic [9:0] cpc [5] = '{10'h100, 10'h110, 10'h120, 10'h130, 10'h140};
    logic [2:0] clv [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       cer [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] rpc [5] = '{10'h121, 10'h111, 10'h101, 10'h051, 10'h052};
    logic [2:0] rlv [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    s_inc = 1'b0; instr = 16'h0050;
    tick;
    if (pc !== 10'h050) begin bad++; $display("FAIL jump_050 got=%h exp=050", pc); end
    total++;
    s_inc = 1'b1; s_call = 1'b1;
    for (int k = 0; k < 5; k++) begin
      instr = 16'h0100 + 16'(k * 16);
      tick;
      if ({pc, stk_lvl, stk_err} !== {cpc[k], clv[k], cer[k]}) begin bad++; $display("FAIL nest_call%0d got pc=%h lvl=%0d err=%b exp pc=%h lvl=%0d err=%b", k, pc, stk_lvl, stk_err, cpc[k], clv[k], cer[k]); end
      total++;
    end
    s_call = 1'b0; s_ret = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      if ({pc, stk_lvl, stk_err} !== {rpc[k], rlv[k], 1'b1}) begin bad++; $display("FAIL nest_ret%0d got pc=%h lvl=%0d err=%b exp pc=%h lvl=%0d err=1", k, pc, stk_lvl, stk_err, rpc[k], rlv[k]); end
      total++;
    end
    s_ret = 1'b0;
  endtask

  task automatic test_async_reset;
    s_call = 1'b1; instr = 16'h0005;
    drive(16'h0005, 0, 3'b000, 0, 1);
    tick;
    if ({pc, stk_lvl, z, stk_err} !== {10'h005, 3'd1, 1'b1, 1'b1}) begin bad++; $display("FAIL pre_reset got pc=%h lvl=%0d z=%b err=%b exp pc=005 lvl=1 z=1 err=1", pc, stk_lvl, z, stk_err); end
    total++;
    #2 reset = 1'b0;
    #1;
    if ({pc, stk_lvl, z, c, stk_err} !== 15'h0) begin bad++; $display("FAIL async_reset got pc=%h lvl=%0d z=%b c=%b err=%b exp all 0", pc, stk_lvl, z, c, stk_err); end
    total++;
    tick;
    if ({pc, stk_lvl} !== 13'h0) begin bad++; $display("FAIL reset_hold_call got pc=%h lvl=%0d exp pc=000 lvl=0", pc, stk_lvl); end
    total++;
    s_call = 1'b0; wez = 1'b0;
    reset = 1'b1;
    tick;
    if ({pc, stk_lvl, stk_err} !== {10'h001, 3'd0, 1'b0}) begin bad++; $display("FAIL post_reset_fetch got pc=%h lvl=%0d err=%b exp pc=001 lvl=0 err=0", pc, stk_lvl, stk_err); end
    total++;
  endtask

  task automatic test_carry;
    for (int k = 0; k < 7; k++) begin
      drive(carry_rows[k].i, carry_rows[k].inm, carry_rows[k].o, carry_rows[k].w3, carry_rows[k].wz);
      tick;
      if (k > 0 && {z, c} !== {carry_rows[k].ez, carry_rows[k].ec}) begin bad++; $display("FAIL carry_row%0d got z=%b c=%b exp z=%b c=%b", k, z, c, carry_rows[k].ez, carry_rows[k].ec); end
      if (k > 0) total++;
    end
    drive(16'h0000, 0, 3'b000, 0, 0);
  endtask

  initial begin
    test_reset;
    test_opcode;
    test_alu;
    test_call_ret;
    test_wrap_and_priority;
    test_overflow;
    test_async_reset;
    test_carry;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
